// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared address map, region/access encodings and the address
//             decoder for the load-store unit.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Memory-mapped register addresses (only addr[15:0] is decoded)
    localparam logic [15:0] c_ram_last  = 16'h1FFF;
    localparam logic [15:0] c_ledr_addr = 16'h7000;
    localparam logic [15:0] c_hex_addr  = 16'h7010;
    localparam logic [15:0] c_sw_addr   = 16'h7800;
    localparam logic [15:0] c_tmr_base  = 16'h7C00;
    localparam logic [15:0] c_tcnt_off  = 16'h0000;
    localparam logic [15:0] c_tcmp_off  = 16'h0004;
    localparam logic [15:0] c_tstat_off = 16'h0008;

    // Timer register select codes
    localparam logic [1:0] c_tsel_tcnt  = 2'd0;
    localparam logic [1:0] c_tsel_tcmp  = 2'd1;
    localparam logic [1:0] c_tsel_tstat = 2'd2;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_LEDR,
        REGION_HEX,
        REGION_SW,
        REGION_TCNT,
        REGION_TCMP,
        REGION_TSTAT,
        REGION_NONE
    } region_e;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_B,
        LD_H,
        LD_W,
        LD_BU,
        LD_HU
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_B,
        ST_H,
        ST_W
    } st_width_e;

    // Registers are matched on the word address so that byte/halfword
    // accesses inside a register word reach the right lanes.
    function automatic region_e decode_region(input logic [15:0] a);
        localparam logic [15:0] c_tcnt_addr  = c_tmr_base + c_tcnt_off;
        localparam logic [15:0] c_tcmp_addr  = c_tmr_base + c_tcmp_off;
        localparam logic [15:0] c_tstat_addr = c_tmr_base + c_tstat_off;
        if (a <= c_ram_last)                  return REGION_RAM;
        if (a[15:2] == c_ledr_addr[15:2])     return REGION_LEDR;
        if (a[15:2] == c_hex_addr[15:2])      return REGION_HEX;
        if (a[15:2] == c_sw_addr[15:2])       return REGION_SW;
        if (a[15:2] == c_tcnt_addr[15:2])     return REGION_TCNT;
        if (a[15:2] == c_tcmp_addr[15:2])     return REGION_TCMP;
        if (a[15:2] == c_tstat_addr[15:2])    return REGION_TSTAT;
        return REGION_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_timer
//  Purpose  : Free-running 32-bit timer with compare register and a sticky
//             match flag (W1C). Only built when LSU_TIMER_EN is defined.
//  Ports    : clk, rst (sync, active-high)
//             i_we     - store targets a timer register (lanes already gated)
//             i_be     - byte-lane strobes
//             i_wdata  - lane-positioned store data
//             i_sel    - register select (TCNT/TCMP/TSTAT)
//             o_rdata  - selected register value
//             o_irq    - match flag
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef LSU_TIMER_EN
module lsu_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_rdata,
    output logic        o_irq
);
    import lsu_pkg::*;

    logic [31:0] r_tcnt;
    logic [31:0] r_tcmp;
    logic        r_flag;

    logic [31:0] w_mask;
    logic        w_wr_tcnt;
    logic        w_wr_tcmp;
    logic        w_clr;

    assign w_mask    = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
    assign w_wr_tcnt = i_we && (i_sel == c_tsel_tcnt) && (i_be != 4'b0000);
    assign w_wr_tcmp = i_we && (i_sel == c_tsel_tcmp);
    assign w_clr     = i_we && (i_sel == c_tsel_tstat) && i_be[0] && i_wdata[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= 32'h0000_0000;
            r_tcmp <= 32'hFFFF_FFFF;
            r_flag <= 1'b0;
        end else begin
            // A store replaces the increment; unwritten lanes keep the old count
            if (w_wr_tcnt)
                r_tcnt <= (r_tcnt & ~w_mask) | (i_wdata & w_mask);
            else
                r_tcnt <= r_tcnt + 32'd1;
            if (w_wr_tcmp)
                r_tcmp <= (r_tcmp & ~w_mask) | (i_wdata & w_mask);
            // Set has priority over a coincident clear
            if (r_tcnt == r_tcmp)
                r_flag <= 1'b1;
            else if (w_clr)
                r_flag <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_sel)
            c_tsel_tcnt:  o_rdata = r_tcnt;
            c_tsel_tcmp:  o_rdata = r_tcmp;
            c_tsel_tstat: o_rdata = {31'b0, r_flag};
            default:      o_rdata = 32'h0000_0000;
        endcase
    end

    assign o_irq = r_flag;

endmodule
`endif
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load-store unit: data RAM, LEDR/HEX output registers, switch
//             input port and optional timer (macro LSU_TIMER_EN).
//  Ports    : clk_i, rst_ni (sync, active-low)
//             addr_i, st_data_i, mem_wren_i, sb/sh/sw_en_i  - store side
//             lb/lh/lw/lbu/lhu_en_i                         - load type
//             io_sw_i                                       - switch inputs
//             ld_data_o (comb), misalign_o (comb)
//             io_ledr_o, io_hex_o (registered), irq_o (timer match)
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int DMEM_AW = 11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic        mem_wren_i,
    input  logic        sb_en_i,
    input  logic        sh_en_i,
    input  logic        sw_en_i,
    input  logic        lb_en_i,
    input  logic        lh_en_i,
    input  logic        lw_en_i,
    input  logic        lbu_en_i,
    input  logic        lhu_en_i,
    input  logic [31:0] io_sw_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_hex_o,
    output logic        misalign_o,
    output logic        irq_o
);
    import lsu_pkg::*;

    localparam int c_ram_words = 2 ** DMEM_AW;

    logic [15:0]        w_unused_addr_hi;
    region_e            w_region_raw;
    region_e            w_region;
    st_width_e          w_st_width;
    ld_type_e           w_ld_type;
    logic               w_mis_st;
    logic               w_mis_ld;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [DMEM_AW-1:0] w_widx;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_tmr_rdata;
    logic               w_irq;

    logic [31:0]        r_mem [c_ram_words];
    logic [31:0]        r_ledr;
    logic [31:0]        r_hex;

    assign w_unused_addr_hi = addr_i[31:16];
    assign w_region_raw     = decode_region(addr_i[15:0]);
    assign w_widx           = addr_i[DMEM_AW+1:2];

`ifdef LSU_TIMER_EN
    assign w_region = w_region_raw;
`else
    // Without the timer its window is just unmapped space
    always_comb begin
        w_region = w_region_raw;
        if (w_region_raw == REGION_TCNT || w_region_raw == REGION_TCMP ||
            w_region_raw == REGION_TSTAT)
            w_region = REGION_NONE;
    end
`endif

    // Anything other than a clean one-hot enable set decodes to "none"
    always_comb begin
        w_st_width = ST_NONE;
        case ({sb_en_i, sh_en_i, sw_en_i})
            3'b100:  w_st_width = ST_B;
            3'b010:  w_st_width = ST_H;
            3'b001:  w_st_width = ST_W;
            default: w_st_width = ST_NONE;
        endcase
    end

    always_comb begin
        w_ld_type = LD_NONE;
        case ({lb_en_i, lh_en_i, lw_en_i, lbu_en_i, lhu_en_i})
            5'b10000: w_ld_type = LD_B;
            5'b01000: w_ld_type = LD_H;
            5'b00100: w_ld_type = LD_W;
            5'b00010: w_ld_type = LD_BU;
            5'b00001: w_ld_type = LD_HU;
            default:  w_ld_type = LD_NONE;
        endcase
    end

    assign w_mis_st = ((w_st_width == ST_H) && addr_i[0]) ||
                      ((w_st_width == ST_W) && (addr_i[1:0] != 2'b00));
    assign w_mis_ld = (((w_ld_type == LD_H) || (w_ld_type == LD_HU)) && addr_i[0]) ||
                      ((w_ld_type == LD_W) && (addr_i[1:0] != 2'b00));
    assign misalign_o = w_mis_st || w_mis_ld;

    // Lane strobes and lane-replicated data; shared by every writable target
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = st_data_i;
        case (w_st_width)
            ST_B: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{st_data_i[7:0]}};
            end
            ST_H: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data_i[15:0]}};
            end
            ST_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (!mem_wren_i || w_mis_st)
            w_be = 4'b0000;
    end

    // RAM is intentionally not reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (w_region == REGION_RAM && w_be[i])
                r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ledr <= 32'h0000_0000;
            r_hex  <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_region == REGION_LEDR && w_be[i])
                    r_ledr[8*i +: 8] <= w_wdata[8*i +: 8];
                if (w_region == REGION_HEX && w_be[i])
                    r_hex[8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign io_ledr_o = r_ledr;
    assign io_hex_o  = r_hex;

`ifdef LSU_TIMER_EN
    logic       w_rst;
    logic       w_tmr_we;
    logic [1:0] w_tsel;

    assign w_rst    = ~rst_ni;
    assign w_tmr_we = (w_region == REGION_TCNT) || (w_region == REGION_TCMP) ||
                      (w_region == REGION_TSTAT);

    always_comb begin
        w_tsel = c_tsel_tcnt;
        case (w_region)
            REGION_TCMP:  w_tsel = c_tsel_tcmp;
            REGION_TSTAT: w_tsel = c_tsel_tstat;
            default:      w_tsel = c_tsel_tcnt;
        endcase
    end

    lsu_timer u_timer (
        .clk     (clk_i),
        .rst     (w_rst),
        .i_we    (w_tmr_we),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .i_sel   (w_tsel),
        .o_rdata (w_tmr_rdata),
        .o_irq   (w_irq)
    );
`else
    assign w_tmr_rdata = 32'h0000_0000;
    assign w_irq       = 1'b0;
`endif

    assign irq_o = w_irq;

    always_comb begin
        w_rword = 32'h0000_0000;
        case (w_region)
            REGION_RAM:   w_rword = r_mem[w_widx];
            REGION_LEDR:  w_rword = r_ledr;
            REGION_HEX:   w_rword = r_hex;
            REGION_SW:    w_rword = io_sw_i;
            REGION_TCNT,
            REGION_TCMP,
            REGION_TSTAT: w_rword = w_tmr_rdata;
            default:      w_rword = 32'h0000_0000;
        endcase
    end

    always_comb begin
        w_byte = w_rword[7:0];
        case (addr_i[1:0])
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            2'd3:    w_byte = w_rword[31:24];
            default: w_byte = w_rword[7:0];
        endcase
        w_half = addr_i[1] ? w_rword[31:16] : w_rword[15:0];
    end

    always_comb begin
        ld_data_o = 32'h0000_0000;
        if (!w_mis_ld) begin
            case (w_ld_type)
                LD_B:    ld_data_o = {{24{w_byte[7]}}, w_byte};
                LD_BU:   ld_data_o = {24'h0, w_byte};
                LD_H:    ld_data_o = {{16{w_half[15]}}, w_half};
                LD_HU:   ld_data_o = {16'h0, w_half};
                LD_W:    ld_data_o = w_rword;
                default: ld_data_o = 32'h0000_0000;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu: directed vector table, timer and
//             reset sequences, and random traffic against a byte-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

`ifdef LSU_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] addr_i, st_data_i, io_sw_i;
    logic        mem_wren_i;
    logic        sb_en_i, sh_en_i, sw_en_i;
    logic        lb_en_i, lh_en_i, lw_en_i, lbu_en_i, lhu_en_i;
    logic [31:0] ld_data_o, io_ledr_o, io_hex_o;
    logic        misalign_o, irq_o;

    always #5 clk = ~clk;

    lsu #(.DMEM_AW(11)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .addr_i(addr_i), .st_data_i(st_data_i),
        .mem_wren_i(mem_wren_i), .sb_en_i(sb_en_i), .sh_en_i(sh_en_i), .sw_en_i(sw_en_i),
        .lb_en_i(lb_en_i), .lh_en_i(lh_en_i), .lw_en_i(lw_en_i), .lbu_en_i(lbu_en_i),
        .lhu_en_i(lhu_en_i), .io_sw_i(io_sw_i), .ld_data_o(ld_data_o),
        .io_ledr_o(io_ledr_o), .io_hex_o(io_hex_o), .misalign_o(misalign_o), .irq_o(irq_o)
    );

    typedef enum int {OP_NOP, OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU} op_e;

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- reference model: byte-addressed view ----------------
    logic [7:0]  m_mem [0:8191];
    logic [31:0] m_ledr, m_hex, m_tcnt, m_tcmp;
    logic        m_flag;

    function automatic int op_size(input op_e op);
        case (op)
            OP_SB, OP_LB, OP_LBU: return 1;
            OP_SH, OP_LH, OP_LHU: return 2;
            OP_SW, OP_LW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_store(input op_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit is_load(input op_e op);
        return op_size(op) != 0 && !is_store(op);
    endfunction

    function automatic bit m_mis(input op_e op, input logic [31:0] a);
        int sz;
        sz = op_size(op);
        return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    endfunction

    // 0 RAM, 1 LEDR, 2 HEX, 3 SW, 4 TCNT, 5 TCMP, 6 TSTAT, 7 unmapped
    function automatic int m_region(input logic [31:0] a);
        logic [15:0] lo, w;
        lo = a[15:0];
        w  = lo & 16'hFFFC;
        if (lo < 16'h2000) return 0;
        if (w == 16'h7000) return 1;
        if (w == 16'h7010) return 2;
        if (w == 16'h7800) return 3;
        if (TIMER_EN) begin
            if (w == 16'h7C00) return 4;
            if (w == 16'h7C04) return 5;
            if (w == 16'h7C08) return 6;
        end
        return 7;
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int wi;
        wi = int'(a[12:0] & 13'h1FFC);
        case (m_region(a))
            0: return {m_mem[wi+3], m_mem[wi+2], m_mem[wi+1], m_mem[wi]};
            1: return m_ledr;
            2: return m_hex;
            3: return io_sw_i;
            4: return m_tcnt;
            5: return m_tcmp;
            6: return {31'b0, m_flag};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input op_e op, input logic [31:0] a);
        logic [31:0] v;
        if (!is_load(op) || m_mis(op, a)) return 32'h0;
        v = m_word(a) >> (8 * int'(a[1:0]));
        if (op_size(op) == 1) begin
            v = v & 32'hFF;
            if (op == OP_LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op_size(op) == 2) begin
            v = v & 32'hFFFF;
            if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic m_step(input op_e op, input logic [31:0] a, input logic [31:0] d,
                          input logic wren, input logic rst_n);
        logic [31:0] old_cnt, old_cmp, nxt_cnt;
        logic        old_flag, clr, wrote;
        logic [7:0]  v;
        int          rg, base, b;
        if (!rst_n) begin
            m_ledr = 0; m_hex = 0; m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF; m_flag = 0;
            return;
        end
        old_cnt = m_tcnt; old_cmp = m_tcmp; old_flag = m_flag;
        nxt_cnt = old_cnt + 1; clr = 0; wrote = 0;
        if (is_store(op) && wren && !m_mis(op, a)) begin
            rg   = m_region(a);
            base = int'(a[12:0] & 13'h1FFC);
            for (int i = 0; i < op_size(op); i++) begin
                b = int'(a[1:0]) + i;
                v = d[8*i +: 8];
                case (rg)
                    0: m_mem[base+b] = v;
                    1: m_ledr[8*b +: 8] = v;
                    2: m_hex[8*b +: 8] = v;
                    4: begin
                        if (!wrote) begin nxt_cnt = old_cnt; wrote = 1; end
                        nxt_cnt[8*b +: 8] = v;
                    end
                    5: m_tcmp[8*b +: 8] = v;
                    6: if (b == 0 && v[0]) clr = 1;
                    default: ;
                endcase
            end
        end
        if (TIMER_EN) begin
            m_tcnt = nxt_cnt;
            m_flag = (old_cnt == old_cmp) ? 1'b1 : (clr ? 1'b0 : old_flag);
        end
    endtask

    // One bus cycle: drive on negedge, check comb outputs, clock, check regs
    task automatic do_cycle(input op_e op, input logic [31:0] a, input logic [31:0] d,
                            input logic wren, input logic rst_n,
                            output logic [31:0] obs_ld, output logic obs_mis);
        @(negedge clk);
        rst_ni = rst_n; addr_i = a; st_data_i = d; mem_wren_i = wren;
        sb_en_i = (op == OP_SB); sh_en_i = (op == OP_SH); sw_en_i = (op == OP_SW);
        lb_en_i = (op == OP_LB); lh_en_i = (op == OP_LH); lw_en_i = (op == OP_LW);
        lbu_en_i = (op == OP_LBU); lhu_en_i = (op == OP_LHU);
        #1;
        obs_ld = ld_data_o; obs_mis = misalign_o;
        check("ld_data", ld_data_o, m_load(op, a));
        check("misalign", {31'b0, misalign_o}, {31'b0, m_mis(op, a)});
        @(posedge clk);
        m_step(op, a, d, wren, rst_n);
        #1;
        check("ledr", io_ledr_o, m_ledr);
        check("hex", io_hex_o, m_hex);
        check("irq", {31'b0, irq_o}, {31'b0, m_flag});
    endtask

    task automatic cyc(input op_e op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] l; logic m;
        do_cycle(op, a, d, 1'b1, 1'b1, l, m);
    endtask

    vec_t        vecs [22];
    logic [31:0] obs_ld;
    logic        obs_mis;

    initial begin
        rst_ni = 0; addr_i = 0; st_data_i = 0; mem_wren_i = 0; io_sw_i = 32'h1234;
        {sb_en_i, sh_en_i, sw_en_i, lb_en_i, lh_en_i, lw_en_i, lbu_en_i, lhu_en_i} = '0;

        vecs[0]  = '{OP_SW,  32'h0000_0100, 32'h8000_80FF, 32'h0,         1'b0};
        vecs[1]  = '{OP_LB,  32'h0000_0100, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{OP_LBU, 32'h0000_0101, 32'h0,         32'h0000_0080, 1'b0};
        vecs[3]  = '{OP_LH,  32'h0000_0102, 32'h0,         32'hFFFF_8000, 1'b0};
        vecs[4]  = '{OP_LHU, 32'h0000_0102, 32'h0,         32'h0000_8000, 1'b0};
        vecs[5]  = '{OP_SW,  32'h0000_0200, 32'h1122_3344, 32'h0,         1'b0};
        vecs[6]  = '{OP_SB,  32'h0000_0203, 32'h0000_00AB, 32'h0,         1'b0};
        vecs[7]  = '{OP_LW,  32'h0000_0200, 32'h0,         32'hAB22_3344, 1'b0};
        vecs[8]  = '{OP_SH,  32'h0000_0101, 32'h0000_BEEF, 32'h0,         1'b1};
        vecs[9]  = '{OP_LW,  32'h0000_0100, 32'h0,         32'h8000_80FF, 1'b0};
        vecs[10] = '{OP_LW,  32'h0000_0102, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{OP_SW,  32'h0000_7000, 32'h0000_005A, 32'h0,         1'b0};
        vecs[12] = '{OP_LW,  32'h0000_7000, 32'h0,         32'h0000_005A, 1'b0};
        vecs[13] = '{OP_SW,  32'h0000_7800, 32'h0000_FFFF, 32'h0,         1'b0};
        vecs[14] = '{OP_LW,  32'h0000_7800, 32'h0,         32'h0000_1234, 1'b0};
        vecs[15] = '{OP_LW,  32'h0000_7F00, 32'h0,         32'h0,         1'b0};
        vecs[16] = '{OP_LW,  32'hABCD_0100, 32'h0,         32'h8000_80FF, 1'b0};
        vecs[17] = '{OP_NOP, 32'h0000_0100, 32'h0,         32'h0,         1'b0};
        vecs[18] = '{OP_SH,  32'h0000_7012, 32'h0000_CAFE, 32'h0,         1'b0};
        vecs[19] = '{OP_LB,  32'h0000_7013, 32'h0,         32'hFFFF_FFCA, 1'b0};
        vecs[20] = '{OP_LHU, 32'h0000_7012, 32'h0,         32'h0000_CAFE, 1'b0};
        vecs[21] = '{OP_LH,  32'h0000_0203, 32'h0,         32'h0,         1'b1};

        // Reset and reset-state checks
        do_cycle(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, obs_ld, obs_mis);
        do_cycle(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, obs_ld, obs_mis);
        check("rst_ledr", io_ledr_o, 32'h0);
        check("rst_hex", io_hex_o, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        do_cycle(OP_LW, 32'h0000_7C04, 32'h0, 1'b0, 1'b1, obs_ld, obs_mis);
`ifdef LSU_TIMER_EN
        check("rst_tcmp", obs_ld, 32'hFFFF_FFFF);
`else
        check("tcmp_unmapped", obs_ld, 32'h0);
`endif

        // Known RAM window so loads compare against defined model state
        for (int w = 0; w < 256; w++) cyc(OP_SW, 32'(w * 4), 32'h0);

        // Directed vectors
        for (int i = 0; i < 22; i++) begin
            do_cycle(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, 1'b1, obs_ld, obs_mis);
            check($sformatf("vec%0d_ld", i), obs_ld, vecs[i].exp_ld);
            check($sformatf("vec%0d_mis", i), {31'b0, obs_mis}, {31'b0, vecs[i].exp_mis});
        end
        check("ledr_5a", io_ledr_o, 32'h0000_005A);
        check("hex_cafe", io_hex_o, 32'hCAFE_0000);

`ifdef LSU_TIMER_EN
        cyc(OP_SW, 32'h0000_7C04, 32'd5);
        cyc(OP_SW, 32'h0000_7C00, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(OP_NOP, 32'h0, 32'h0);
            check($sformatf("irq_pre%0d", k), {31'b0, irq_o}, 32'h0);
        end
        cyc(OP_NOP, 32'h0, 32'h0);
        check("irq_match", {31'b0, irq_o}, 32'h1);
        cyc(OP_SW, 32'h0000_7C08, 32'h1);
        check("irq_w1c", {31'b0, irq_o}, 32'h0);
        cyc(OP_SW, 32'h0000_7C00, 32'd4);
        cyc(OP_NOP, 32'h0, 32'h0);
        cyc(OP_SW, 32'h0000_7C08, 32'h1);
        check("irq_set_wins", {31'b0, irq_o}, 32'h1);
        cyc(OP_SW, 32'h0000_7C08, 32'h1);
        check("irq_clr2", {31'b0, irq_o}, 32'h0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            op_e         op;
            logic [31:0] a, d;
            logic        wr;
            op = op_e'($urandom_range(0, 8));
            case ($urandom_range(0, 5))
                0: a = 32'($urandom_range(0, 16'h03FF));
                1: a = 32'h7000 + 32'($urandom_range(0, 3));
                2: a = 32'h7010 + 32'($urandom_range(0, 3));
                3: a = 32'h7800 + 32'($urandom_range(0, 3));
                4: a = 32'h7C00 + 32'($urandom_range(0, 11));
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h2000; 1: a = 32'h7004; 2: a = 32'h7C0C; default: a = 32'hFFFC;
                    endcase
                    a = a + 32'($urandom_range(0, 3));
                end
            endcase
            a[31:16] = 16'($urandom);
            d  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : 32'($urandom);
            wr = ($urandom_range(0, 4) != 0);
            io_sw_i = $urandom;
            do_cycle(op, a, d, wr, 1'b1, obs_ld, obs_mis);
        end

        // Reset in the middle of a store
`ifdef LSU_TIMER_EN
        cyc(OP_SW, 32'h0000_7C00, 32'h10);
        cyc(OP_SW, 32'h0000_7C04, 32'h11);
        cyc(OP_NOP, 32'h0, 32'h0);
        check("irq_before_rst", {31'b0, irq_o}, 32'h1);
`endif
        cyc(OP_SW, 32'h0000_7000, 32'hFFFF_0001);
        do_cycle(OP_SW, 32'h0000_7000, 32'h0000_0055, 1'b1, 1'b0, obs_ld, obs_mis);
        check("mid_rst_ledr", io_ledr_o, 32'h0);
        check("mid_rst_irq", {31'b0, irq_o}, 32'h0);
        do_cycle(OP_LW, 32'h0000_7C00, 32'h0, 1'b0, 1'b1, obs_ld, obs_mis);
        check("mid_rst_tcnt", obs_ld, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
